// File: rtl/cpu_control_seq.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_seq
// Description : Hardwired Moore control unit for the 32-bit DataPath.
//               Sequences instruction fetch (T0-T2), decode (T3) and
//               execute (T4-T7) for R-format ALU, immediate ALU, ld, st,
//               nop and halt. Every output is decoded from the current
//               state plus the IR fields latched in the DataPath, so at
//               most one source drives the internal bus in any cycle.
//
// Ports       : clock      - system clock, rising-edge active
//               clear      - synchronous active-high reset (to RST)
//               IR         - instruction register contents
//                            opcode=[31:27] Ra=[26:23] Rb=[22:19] Rc=[18:15]
//               mem_ready  - memory finishes the current Read/Write
//               Rin/Rout   - one-hot GPR load / bus-drive selects
//               PCout..Cout- DataPath strobes
//               Read/Write - memory strobes (Read also muxes MDR input)
//               alu_op     - ALU operation code, valid in T4 only
//               run        - high in T0..T7
//               illegal    - one-cycle pulse on undefined opcode in T3
//               state_dbg  - state encoding: RST=0, T0..T7=1..8, HALT=9
//
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_seq #(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     IR,
    input  logic            mem_ready,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlo_out,
    output logic            Cout,
    output logic            Read,
    output logic            Write,
    output logic [OPW-1:0]  alu_op,
    output logic            run,
    output logic            illegal,
    output logic [3:0]      state_dbg
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    // ------------------------------------------------------------------------
    // Opcodes and fixed ALU codes
    // ------------------------------------------------------------------------
    localparam logic [4:0] c_OP_LD     = 5'b00000;
    localparam logic [4:0] c_OP_ST     = 5'b00001;
    localparam logic [4:0] c_OP_ALU_LO = 5'b00011;  // add
    localparam logic [4:0] c_OP_ALU_HI = 5'b01010;  // rol
    localparam logic [4:0] c_OP_ADDI   = 5'b01100;
    localparam logic [4:0] c_OP_ANDI   = 5'b01101;
    localparam logic [4:0] c_OP_ORI    = 5'b01110;
    localparam logic [4:0] c_OP_NOP    = 5'b11010;
    localparam logic [4:0] c_OP_HALT   = 5'b11011;

    localparam logic [4:0] c_ALU_ADD   = 5'b00011;
    localparam logic [4:0] c_ALU_AND   = 5'b00101;
    localparam logic [4:0] c_ALU_OR    = 5'b00110;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    state_t r_state_q;
    state_t w_state_d;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state_q <= ST_RST;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ------------------------------------------------------------------------
    // IR field extraction and instruction classification
    // ------------------------------------------------------------------------
    logic [4:0] w_opcode;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    logic       w_unused_ir;

    assign w_opcode = IR[31:27];
    assign w_ra     = IR[26:23];
    assign w_rb     = IR[22:19];
    assign w_rc     = IR[18:15];
    // The constant field is consumed by the DataPath on Cout, not here.
    assign w_unused_ir = ^IR[14:0];

    logic w_is_ld;
    logic w_is_st;
    logic w_is_alu;
    logic w_is_imm;
    logic w_is_nop;
    logic w_is_halt;
    logic w_is_mem;
    logic w_is_ill;

    always_comb begin
        w_is_ld   = (w_opcode == c_OP_LD);
        w_is_st   = (w_opcode == c_OP_ST);
        w_is_alu  = (w_opcode >= c_OP_ALU_LO) && (w_opcode <= c_OP_ALU_HI);
        w_is_imm  = (w_opcode == c_OP_ADDI) || (w_opcode == c_OP_ANDI) ||
                    (w_opcode == c_OP_ORI);
        w_is_nop  = (w_opcode == c_OP_NOP);
        w_is_halt = (w_opcode == c_OP_HALT);
        w_is_mem  = w_is_ld || w_is_st;
        w_is_ill  = !(w_is_mem || w_is_alu || w_is_imm || w_is_nop || w_is_halt);
    end

    // Immediate-format and address-calculation ALU code.
    logic [4:0] w_imm_alu;

    always_comb begin
        w_imm_alu = c_ALU_ADD;
        if (w_opcode == c_OP_ANDI) begin
            w_imm_alu = c_ALU_AND;
        end else if (w_opcode == c_OP_ORI) begin
            w_imm_alu = c_ALU_OR;
        end
    end

    // Register-index to one-hot select.
    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        return NREG'(1) << idx;
    endfunction

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        Rin       = '0;
        Rout      = '0;
        PCout     = 1'b0;
        PCin      = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        Zlo_out   = 1'b0;
        Cout      = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        alu_op    = '0;
        run       = 1'b1;
        illegal   = 1'b0;

        case (r_state_q)
            ST_RST: begin
                run       = 1'b0;
                w_state_d = ST_T0;
            end

            // Fetch: MAR <- PC, Z <- PC + 1 in the same cycle.
            ST_T0: begin
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zin       = 1'b1;
                w_state_d = ST_T1;
            end

            // PC <- Z and MDR <- M[MAR]. All four strobes are held during
            // the wait; Z is stable so reloading PC each cycle is benign.
            ST_T1: begin
                Zlo_out = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) begin
                    w_state_d = ST_T2;
                end
            end

            ST_T2: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                w_state_d = ST_T3;
            end

            // Decode: IR now holds the new instruction.
            ST_T3: begin
                if (w_is_alu || w_is_imm || w_is_mem) begin
                    Rout      = onehot(w_rb);
                    Yin       = 1'b1;
                    w_state_d = ST_T4;
                end else if (w_is_halt) begin
                    w_state_d = ST_HALT;
                end else begin
                    illegal   = w_is_ill;
                    w_state_d = ST_T0;
                end
            end

            ST_T4: begin
                if (w_is_alu) begin
                    Rout   = onehot(w_rc);
                    alu_op = OPW'(w_opcode);
                end else begin
                    Cout   = 1'b1;
                    alu_op = OPW'(w_imm_alu);
                end
                Zin       = 1'b1;
                w_state_d = ST_T5;
            end

            ST_T5: begin
                Zlo_out = 1'b1;
                if (w_is_mem) begin
                    MARin     = 1'b1;
                    w_state_d = ST_T6;
                end else begin
                    Rin       = onehot(w_ra);
                    w_state_d = ST_T0;
                end
            end

            // ld: MDR <- M[MAR] with wait. st: MDR <- Ra from the bus.
            ST_T6: begin
                MDRin = 1'b1;
                if (w_is_ld) begin
                    Read = 1'b1;
                    if (mem_ready) begin
                        w_state_d = ST_T7;
                    end
                end else begin
                    Rout      = onehot(w_ra);
                    w_state_d = ST_T7;
                end
            end

            ST_T7: begin
                if (w_is_ld) begin
                    MDRout    = 1'b1;
                    Rin       = onehot(w_ra);
                    w_state_d = ST_T0;
                end else begin
                    Write = 1'b1;
                    if (mem_ready) begin
                        w_state_d = ST_T0;
                    end
                end
            end

            ST_HALT: begin
                run       = 1'b0;
                w_state_d = ST_HALT;
            end

            default: begin
                run       = 1'b0;
                w_state_d = ST_RST;
            end
        endcase
    end

    assign state_dbg = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_seq
// Description : Directed, table-driven bench for cpu_control_seq, plus
//               hand-written sequences for halt, clear-from-halt and
//               clear during a store write wait.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_seq;

    logic        clock;
    logic        clear;
    logic [31:0] ir_s;
    logic        mem_ready;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlo_out, Cout, Read, Write;
    logic [4:0]  alu_op;
    logic        run;
    logic        illegal;
    logic [3:0]  state_dbg;

    cpu_control_seq #(.NREG(16), .OPW(5)) dut (
        .clock     (clock),
        .clear     (clear),
        .IR        (ir_s),
        .mem_ready (mem_ready),
        .Rin       (Rin),
        .Rout      (Rout),
        .PCout     (PCout),
        .PCin      (PCin),
        .IncPC     (IncPC),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .Yin       (Yin),
        .Zin       (Zin),
        .Zlo_out   (Zlo_out),
        .Cout      (Cout),
        .Read      (Read),
        .Write     (Write),
        .alu_op    (alu_op),
        .run       (run),
        .illegal   (illegal),
        .state_dbg (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // State encodings
    localparam logic [3:0] B_RST = 4'd0, B_T0 = 4'd1, B_T1 = 4'd2, B_T2 = 4'd3,
                           B_T3 = 4'd4, B_T4 = 4'd5, B_T5 = 4'd6, B_T6 = 4'd7,
                           B_T7 = 4'd8, B_HALT = 4'd9;

    // Strobe mask bits: {PCout,PCin,IncPC,MARin,MDRin,MDRout,IRin,Yin,Zin,Zlo_out,Cout,Read,Write}
    localparam logic [12:0] S_PCOUT = 13'h1000, S_PCIN  = 13'h0800, S_INCPC  = 13'h0400,
                            S_MARIN = 13'h0200, S_MDRIN = 13'h0100, S_MDROUT = 13'h0080,
                            S_IRIN  = 13'h0040, S_YIN   = 13'h0020, S_ZIN    = 13'h0010,
                            S_ZLO   = 13'h0008, S_COUT  = 13'h0004, S_READ   = 13'h0002,
                            S_WRITE = 13'h0001;

    localparam logic [12:0] F0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
    localparam logic [12:0] F1 = S_ZLO | S_PCIN | S_READ | S_MDRIN;
    localparam logic [12:0] F2 = S_MDROUT | S_IRIN;

    localparam logic [31:0] I_AND  = 32'h28918000;
    localparam logic [31:0] I_ADDI = 32'h611FFFFB;
    localparam logic [31:0] I_LD   = 32'h02280010;
    localparam logic [31:0] I_ST   = 32'h0B380020;
    localparam logic [31:0] I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_ILL  = 32'hF8000000;
    localparam logic [31:0] I_HALT = 32'hD8000000;

    typedef struct {
        logic [31:0] ir;
        logic        mr;
        logic        clr;
        logic [55:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected bundle: {state, Rin, Rout, strobes, alu_op, run, illegal}
    function automatic logic [55:0] pack(input logic [3:0] st, input logic [15:0] rin,
                                         input logic [15:0] rout, input logic [12:0] stb,
                                         input logic [4:0] alu, input logic ill);
        logic r;
        r = (st != B_RST) && (st != B_HALT);
        return {st, rin, rout, stb, alu, r, ill};
    endfunction

    task automatic add(input logic [31:0] ir, input logic mr, input logic clr,
                       input logic [3:0] st, input logic [15:0] rin, input logic [15:0] rout,
                       input logic [12:0] stb, input logic [4:0] alu, input logic ill);
        vec_t v;
        v.ir  = ir;
        v.mr  = mr;
        v.clr = clr;
        v.exp = pack(st, rin, rout, stb, alu, ill);
        tbl.push_back(v);
    endtask

    task automatic add_fetch(input logic [31:0] ir);
        add(ir, 1'b1, 1'b0, B_T0, 16'h0, 16'h0, F0, 5'd0, 1'b0);
        add(ir, 1'b1, 1'b0, B_T1, 16'h0, 16'h0, F1, 5'd0, 1'b0);
        add(ir, 1'b1, 1'b0, B_T2, 16'h0, 16'h0, F2, 5'd0, 1'b0);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [55:0] exp);
        logic [55:0] act;
        act = {state_dbg, Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
               Yin, Zin, Zlo_out, Cout, Read, Write, alu_op, run, illegal};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- build vector table ----------------
        add(32'h0, 1'b1, 1'b0, B_RST, 16'h0, 16'h0, 13'h0, 5'd0, 1'b0);

        // and R1,R2,R3
        add_fetch(I_AND);
        add(I_AND, 1'b1, 1'b0, B_T3, 16'h0,    16'h0004, S_YIN,         5'd0,      1'b0);
        add(I_AND, 1'b1, 1'b0, B_T4, 16'h0,    16'h0008, S_ZIN,         5'b00101,  1'b0);
        add(I_AND, 1'b1, 1'b0, B_T5, 16'h0002, 16'h0,    S_ZLO,         5'd0,      1'b0);

        // addi R2,R3,-5
        add_fetch(I_ADDI);
        add(I_ADDI, 1'b1, 1'b0, B_T3, 16'h0,    16'h0008, S_YIN,          5'd0,     1'b0);
        add(I_ADDI, 1'b1, 1'b0, B_T4, 16'h0,    16'h0,    S_COUT | S_ZIN, 5'b00011, 1'b0);
        add(I_ADDI, 1'b1, 1'b0, B_T5, 16'h0004, 16'h0,    S_ZLO,          5'd0,     1'b0);

        // ld R4,0x10(R5) with a 3-cycle fetch wait and a 2-cycle load wait
        add(I_LD, 1'b1, 1'b0, B_T0, 16'h0, 16'h0, F0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            add(I_LD, 1'b0, 1'b0, B_T1, 16'h0, 16'h0, F1, 5'd0, 1'b0);
        add(I_LD, 1'b1, 1'b0, B_T1, 16'h0, 16'h0, F1, 5'd0, 1'b0);
        add(I_LD, 1'b1, 1'b0, B_T2, 16'h0, 16'h0, F2, 5'd0, 1'b0);
        add(I_LD, 1'b1, 1'b0, B_T3, 16'h0,    16'h0020, S_YIN,            5'd0,     1'b0);
        add(I_LD, 1'b1, 1'b0, B_T4, 16'h0,    16'h0,    S_COUT | S_ZIN,   5'b00011, 1'b0);
        add(I_LD, 1'b0, 1'b0, B_T5, 16'h0,    16'h0,    S_ZLO | S_MARIN,  5'd0,     1'b0);
        add(I_LD, 1'b0, 1'b0, B_T6, 16'h0,    16'h0,    S_READ | S_MDRIN, 5'd0,     1'b0);
        add(I_LD, 1'b0, 1'b0, B_T6, 16'h0,    16'h0,    S_READ | S_MDRIN, 5'd0,     1'b0);
        add(I_LD, 1'b1, 1'b0, B_T6, 16'h0,    16'h0,    S_READ | S_MDRIN, 5'd0,     1'b0);
        add(I_LD, 1'b1, 1'b0, B_T7, 16'h0010, 16'h0,    S_MDROUT,         5'd0,     1'b0);

        // st R6,0x20(R7) with a 2-cycle write wait
        add_fetch(I_ST);
        add(I_ST, 1'b1, 1'b0, B_T3, 16'h0, 16'h0080, S_YIN,           5'd0,     1'b0);
        add(I_ST, 1'b1, 1'b0, B_T4, 16'h0, 16'h0,    S_COUT | S_ZIN,  5'b00011, 1'b0);
        add(I_ST, 1'b1, 1'b0, B_T5, 16'h0, 16'h0,    S_ZLO | S_MARIN, 5'd0,     1'b0);
        add(I_ST, 1'b0, 1'b0, B_T6, 16'h0, 16'h0040, S_MDRIN,         5'd0,     1'b0);
        add(I_ST, 1'b0, 1'b0, B_T7, 16'h0, 16'h0,    S_WRITE,         5'd0,     1'b0);
        add(I_ST, 1'b0, 1'b0, B_T7, 16'h0, 16'h0,    S_WRITE,         5'd0,     1'b0);
        add(I_ST, 1'b1, 1'b0, B_T7, 16'h0, 16'h0,    S_WRITE,         5'd0,     1'b0);

        // nop, illegal, then halt
        add_fetch(I_NOP);
        add(I_NOP, 1'b1, 1'b0, B_T3, 16'h0, 16'h0, 13'h0, 5'd0, 1'b0);
        add_fetch(I_ILL);
        add(I_ILL, 1'b1, 1'b0, B_T3, 16'h0, 16'h0, 13'h0, 5'd0, 1'b1);
        add_fetch(I_HALT);
        add(I_HALT, 1'b1, 1'b0, B_T3, 16'h0, 16'h0, 13'h0, 5'd0, 1'b0);

        // ---------------- reset ----------------
        clear     = 1'b1;
        ir_s      = 32'h0;
        mem_ready = 1'b0;
        step();
        step();
        #1;
        check("reset", pack(B_RST, 16'h0, 16'h0, 13'h0, 5'd0, 1'b0));

        // ---------------- table ----------------
        foreach (tbl[i]) begin
            clear     = tbl[i].clr;
            ir_s      = tbl[i].ir;
            mem_ready = tbl[i].mr;
            #1;
            check($sformatf("vec[%0d]", i), tbl[i].exp);
            step();
        end

        // ---------------- halt holds for 22 cycles ----------------
        for (int i = 0; i < 22; i++) begin
            mem_ready = i[0];
            ir_s      = (i[1]) ? I_ST : I_HALT;
            #1;
            check($sformatf("halt[%0d]", i), pack(B_HALT, 16'h0, 16'h0, 13'h0, 5'd0, 1'b0));
            step();
        end

        // ---------------- clear exits halt ----------------
        clear = 1'b1;
        step();
        clear = 1'b0;
        #1;
        check("halt_clear_rst", pack(B_RST, 16'h0, 16'h0, 13'h0, 5'd0, 1'b0));
        step();
        check("halt_clear_t0", pack(B_T0, 16'h0, 16'h0, F0, 5'd0, 1'b0));

        // ---------------- clear during st write wait ----------------
        ir_s      = I_ST;
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        mem_ready = 1'b0;
        #1;
        check("st_wait_t7", pack(B_T7, 16'h0, 16'h0, S_WRITE, 5'd0, 1'b0));
        step();
        check("st_wait_t7_hold", pack(B_T7, 16'h0, 16'h0, S_WRITE, 5'd0, 1'b0));
        clear = 1'b1;
        step();
        clear = 1'b0;
        #1;
        check("st_wait_clear_rst", pack(B_RST, 16'h0, 16'h0, 13'h0, 5'd0, 1'b0));
        step();
        check("st_wait_clear_t0", pack(B_T0, 16'h0, 16'h0, F0, 5'd0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
